// File: rtl/exp_golomb_decoder.sv
// Exp-Golomb ue(v)/se(v) decoder driving a 16-bit MSB-aligned barrel shifter.
// Codes up to 15 bits decode in one window; longer codes take a prefix shift and then a suffix shift.
module exp_golomb_decoder #(
  parameter int MAX_LZ = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        ShifterReady,
  input  logic [15:0] BitstreamShifted,
  input  logic        Start,
  input  logic        Signed,
  output logic        ShiftEn,
  output logic [4:0]  NumShift,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Value,
  output logic        Error
);

  typedef enum logic [1:0] {IDLE, HEAD, TAIL, ERR} state_e;

  state_e      state_q, state_d;
  logic [4:0]  lz_q, lz_d;
  logic        signed_q, signed_d;
  logic [15:0] value_q, value_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        active;
  logic [4:0]  lz;
  logic [31:0] win32;
  logic [31:0] info;
  logic [15:0] code_num;

  function automatic logic [15:0] se_map(input logic [15:0] k);
    if (k[0]) return (k >> 1) + 16'd1;
    else      return 16'd0 - (k >> 1);
  endfunction

  assign active = !Reset && Enable;
  assign win32  = {BitstreamShifted, 16'h0000};

  // Ascending scan so the most significant set bit wins; all-zero window reports 16.
  always_comb begin
    lz = 5'd16;
    for (int i = 0; i < 16; i++)
      if (BitstreamShifted[i]) lz = 5'(15 - i);
  end

  always_comb begin
    state_d  = state_q;
    lz_d     = lz_q;
    signed_d = signed_q;
    value_d  = value_q;
    done_d   = 1'b0;
    error_d  = error_q;
    ShiftEn  = 1'b0;
    NumShift = 5'd0;
    info     = 32'd0;
    code_num = 16'd0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          signed_d = Signed;
          state_d  = HEAD;
        end
      end
      HEAD: begin
        if (ShifterReady) begin
          if (32'(lz) > 32'(MAX_LZ)) begin
            state_d = ERR;
            error_d = 1'b1;
          end else if (lz <= 5'd7) begin
            // Drop the prefix and marker bit, then keep the lz info bits that follow.
            ShiftEn  = 1'b1;
            NumShift = {lz[3:0], 1'b1};
            info     = (win32 << ({1'b0, lz} + 6'd1)) >> (6'd32 - {1'b0, lz});
            code_num = 16'((32'd1 << lz) - 32'd1 + info);
            value_d  = signed_q ? se_map(code_num) : code_num;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            ShiftEn  = 1'b1;
            NumShift = lz + 5'd1;
            lz_d     = lz;
            state_d  = TAIL;
          end
        end
      end
      TAIL: begin
        if (ShifterReady) begin
          ShiftEn  = 1'b1;
          NumShift = lz_q;
          info     = win32 >> (6'd32 - {1'b0, lz_q});
          code_num = 16'((32'd1 << lz_q) - 32'd1 + info);
          value_d  = signed_q ? se_map(code_num) : code_num;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: ;
    endcase
    // Reset or disable in the same cycle suppresses any shift already decoded.
    if (!active) begin
      ShiftEn  = 1'b0;
      NumShift = 5'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!active) begin
      state_q  <= IDLE;
      lz_q     <= 5'd0;
      signed_q <= 1'b0;
      value_q  <= 16'd0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lz_q     <= lz_d;
      signed_q <= signed_d;
      value_q  <= value_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign Busy  = (state_q == HEAD) || (state_q == TAIL);
  assign Done  = done_q;
  assign Value = value_q;
  assign Error = error_q;

endmodule

// File: doc/exp_golomb_decoder.md
Name: exp_golomb_decoder

Overview:
- Sits directly downstream of the barrel shifter in the CAVLC/slice-data path.
- Consumes the shifter's registered 16-bit MSB-aligned window and drives its shift-enable and shift-amount inputs.
- Decodes one Exp-Golomb syntax element per request, either unsigned ue(v) or signed se(v).
- Used for header fields and for run/level escape paths that precede CAVLC residual decoding.

Parameters:
MAX_LZ, 15, maximum accepted leading-zero count; anything larger is a bitstream error (max code length 2*MAX_LZ+1 = 31 bits).

Ports:
Clk  input  1  clock; all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
Enable  input  1  module enable; low forces IDLE and clears all outputs, same effect as Reset.
ShifterReady  input  1  barrel shifter ready (window valid).
BitstreamShifted  input  16  current window; bit 15 is the next unconsumed bit.
Start  input  1  decode request; sampled only in IDLE.
Signed  input  1  latched with Start: 1 = se(v), 0 = ue(v).
ShiftEn  output  1  shift request to barrel shifter.
NumShift  output  5  bits to consume when ShiftEn=1 (1..16).
Busy  output  1  high in every state except IDLE and ERR.
Done  output  1  one-cycle pulse; Value valid.
Value  output  16  codeNum (ue) or two's-complement result (se); held until next Done.
Error  output  1  sticky; set on a leading-zero overflow.

Behaviour:
- Reset/Enable low: state IDLE; ShiftEn=0, NumShift=0, Busy=0, Done=0, Value=0, Error=0. Applies mid-decode, with no partial shift issued.
- Window timing: a shift issued in cycle t is reflected in BitstreamShifted at cycle t+1. One shift per cycle is allowed back-to-back.
- ShiftEn and NumShift are combinational from state and window. NumShift=0 whenever ShiftEn=0.
- IDLE:
  - Start=1 latches Signed and moves to HEAD.
  - Start while Busy or in ERR is ignored.
- HEAD: waits while ShifterReady=0, with no shift. Otherwise lz = count of leading zeros of the window.
  - Window==0 or lz>MAX_LZ: go to ERR, set Error, no shift, no Done.
  - lz<=7 (code <=15 bits): ShiftEn=1, NumShift=2*lz+1; codeNum = (1<<lz)-1 + window[14-lz -: lz] (0 when lz=0). Register Value and go to IDLE; Done=1 in the next cycle.
  - lz>=8: ShiftEn=1, NumShift=lz+1 (9..16); store lz; go to TAIL.
- TAIL: waits while ShifterReady=0. Otherwise ShiftEn=1, NumShift=lz; codeNum = (1<<lz)-1 + window[15 -: lz]. Register Value, go to IDLE; Done next cycle.
- Arithmetic: codeNum is 16-bit unsigned; the maximum is 65534 at lz=15, so there is no overflow.
- se mapping: codeNum k odd gives +(k+1)/2; k even gives -(k/2); k=0 gives 0. Range is -32767..+32767.
- Latency: short code, Start at cycle t gives Done at t+2. Long code gives Done at t+3. ShifterReady-low cycles add to these.
- Back-to-back: Start may be asserted in the Done cycle (IDLE) and is accepted.
- ERR: stays until Reset or Enable low. Busy=0, Start ignored.

Test Plan:
- ue, window 0x8000 -> one shift NumShift=1; Done at Start+2; Value=0.
- ue, window 0x2800 (00101) -> NumShift=5, Value=4. Same window with Signed=1 -> Value=-2 (0xFFFE).
- ue, lz=7, window 0x01FE -> NumShift=15, Value=254. se with window 0x0100 -> Value=+64.
- ue, lz=10: HEAD window 0x0020 -> NumShift=11; TAIL window 0xFFC0 -> NumShift=10, Value=2046; Done at Start+3. Same with ShifterReady low 2 cycles in TAIL -> Done at Start+5, no extra shifts.
- Window 0x0000 in HEAD -> Error=1, no ShiftEn, no Done, further Start ignored. Then Enable low 1 cycle -> Error=0, IDLE.
- Reset asserted in TAIL -> next cycle all outputs 0 and IDLE. Back-to-back Starts on 1,010,011 stream -> Values 0,1,2 with Done every 2 cycles.
